// File: rtl/toggle_counter_pkg.sv
// Shared definitions for the toggle_counter block: FSM state encoding and
// the default counter width.
package toggle_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/t_ff_cell.sv
// One bit of the counter: a T flip-flop with a synchronous parallel load.
// Load wins over toggle so clear/load/wrap can force an arbitrary value.
module t_ff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q
);

  // Bit state: async reset, then load or toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (ld) begin
      q <= d;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/toggle_counter.sv
// toggle_counter: counts edges (either direction) of an asynchronous level
// input such as an upstream T-latch q. The count register is a synchronous
// chain of t_ff_cell bits; the per-bit toggle enables, load mux and terminal
// compare live here.
// Optional feature: define TOGGLE_COUNTER_DOWN_EN to add a dir input that
// selects down-counting (terminal at zero, wrap reloads max_val).
module toggle_counter
  import toggle_counter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2,   // must be at least 2
  parameter int WRAP        = 1    // 1: wrap to start value, 0: saturate and HOLD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enb,
  input  logic             t_in,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
`ifdef TOGGLE_COUNTER_DOWN_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             busy
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   t_prev_q;
  logic                   t_s;
  logic                   evt;

  state_e                 state_q, state_d;
  logic                   tc_q, tc_d;
  logic                   ovf_q, ovf_d;

  logic [WIDTH-1:0]       cnt_q;
  logic [WIDTH-1:0]       step_mask;
  logic [WIDTH-1:0]       t_vec;
  logic [WIDTH-1:0]       ld_val;
  logic                   ld_en;
  logic                   down;
  logic                   term;
  logic                   load_ok;
  logic                   cnt_evt;

`ifdef TOGGLE_COUNTER_DOWN_EN
  assign down = dir;
`else
  assign down = 1'b0;
`endif

  assign t_s = sync_q[SYNC_STAGES-1];
  // An event is any change of the synchronized level since the last cycle.
  assign evt = t_s ^ t_prev_q;

  // Synchronizer chain and previous-level flop; keeps tracking in every
  // state so re-enabling never sees a stale edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      t_prev_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], t_in};
      t_prev_q <= t_s;
    end
  end

  // Ripple-free step: bit i toggles when all lower bits are 1 (up) or 0 (down)
  always_comb begin : p_step
    logic run;
    run       = 1'b1;
    step_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      step_mask[i] = run;
      run          = run & (down ? ~cnt_q[i] : cnt_q[i]);
    end
  end

  // Load/toggle selection with priority clr > load > event, plus flag next-state
  always_comb begin
    load_ok = load && (state_q != ST_HOLD);
    cnt_evt = (state_q == ST_COUNT) && enb && evt;
    term    = down ? (cnt_q == '0) : (cnt_q == max_val);
    ld_en   = 1'b0;
    ld_val  = '0;
    t_vec   = '0;
    tc_d    = 1'b0;
    if (clr) begin
      ld_en = 1'b1;
    end else if (load_ok) begin
      ld_en  = 1'b1;
      ld_val = load_val;
    end else if (cnt_evt) begin
      if (term) begin
        tc_d = 1'b1;
        if (WRAP != 0) begin
          ld_en  = 1'b1;
          ld_val = down ? max_val : '0;
        end
      end else begin
        t_vec = step_mask;
      end
    end
    ovf_d = clr ? 1'b0 : (ovf_q | tc_d);
  end

  // FSM next state; clr returns to IDLE from anywhere, enb is ignored in HOLD
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (enb) state_d = ST_COUNT;
        ST_COUNT: begin
          if (!enb) begin
            state_d = ST_IDLE;
          end else if (tc_d && (WRAP == 0)) begin
            state_d = ST_HOLD;
          end
        end
        ST_HOLD:  state_d = ST_HOLD;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state and terminal/overflow flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_ff_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .t     (t_vec[i]),
      .ld    (ld_en),
      .d     (ld_val[i]),
      .q     (cnt_q[i])
    );
  end

  assign count = cnt_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q == ST_COUNT);

endmodule

// File: tb/tb_toggle_counter.sv
// Bench for toggle_counter: a wrapping and a saturating instance share the
// same stimulus; directed scenarios plus a randomized run against a
// reference model built from the counting rules.
module tb_toggle_counter;

  localparam int W  = 8;
  localparam int SS = 2;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;

  logic         clk = 1'b0;
  logic         rst_n, enb, t_in, clr, load;
  logic [W-1:0] load_val, max_val;
  logic         dir = 1'b0;

  logic [W-1:0] cnt_w, cnt_s;
  logic         tc_w, ovf_w, busy_w;
  logic         tc_s, ovf_s, busy_s;

  int checks = 0;
  int errors = 0;

  // reference model state, index 0 = saturating, 1 = wrapping
  logic [W-1:0] m_cnt [2];
  logic         m_tc  [2];
  logic         m_ovf [2];
  int           m_mode[2];
  logic         hist  [SS+1];

  always #5 clk = ~clk;

  toggle_counter #(.WIDTH(W), .SYNC_STAGES(SS), .WRAP(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .enb(enb), .t_in(t_in), .clr(clr), .load(load),
    .load_val(load_val), .max_val(max_val),
`ifdef TOGGLE_COUNTER_DOWN_EN
    .dir(dir),
`endif
    .count(cnt_w), .tc(tc_w), .ovf(ovf_w), .busy(busy_w)
  );

  toggle_counter #(.WIDTH(W), .SYNC_STAGES(SS), .WRAP(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .enb(enb), .t_in(t_in), .clr(clr), .load(load),
    .load_val(load_val), .max_val(max_val),
`ifdef TOGGLE_COUNTER_DOWN_EN
    .dir(dir),
`endif
    .count(cnt_s), .tc(tc_s), .ovf(ovf_s), .busy(busy_s)
  );

  task automatic model_step(input int k, input logic ev);
    int nxt;
    m_tc[k] = 1'b0;
    if (clr) begin
      m_cnt[k]  = '0;
      m_ovf[k]  = 1'b0;
      m_mode[k] = M_IDLE;
    end else begin
      nxt = m_mode[k];
      if (m_mode[k] == M_IDLE && enb) nxt = M_RUN;
      else if (m_mode[k] == M_RUN && !enb) nxt = M_IDLE;
      if (load && m_mode[k] != M_HOLD) begin
        m_cnt[k] = load_val;
      end else if (m_mode[k] == M_RUN && enb && ev) begin
        if (dir ? (m_cnt[k] == 0) : (m_cnt[k] == max_val)) begin
          m_tc[k]  = 1'b1;
          m_ovf[k] = 1'b1;
          if (k == 1) m_cnt[k] = dir ? max_val : '0;
          else        nxt = M_HOLD;
        end else begin
          m_cnt[k] = dir ? m_cnt[k] - 1'b1 : m_cnt[k] + 1'b1;
        end
      end
      m_mode[k] = nxt;
    end
  endtask

  // event at an edge = change between the t_in samples taken SS and SS+1 edges earlier
  always @(posedge clk or negedge rst_n) begin
    logic ev;
    if (!rst_n) begin
      for (int i = 0; i <= SS; i++) hist[i] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = '0; m_tc[k] = 1'b0; m_ovf[k] = 1'b0; m_mode[k] = M_IDLE;
      end
    end else begin
      ev = hist[SS-1] ^ hist[SS];
      for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = t_in;
      for (int k = 0; k < 2; k++) model_step(k, ev);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr = 1'b1; step(1); clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enb = 1'b1; t_in = 1'b0; clr = 1'b0; load = 1'b0;
    load_val = '0; max_val = 8'd3;
    for (int i = 0; i < 6; i++) begin
      t_in = ~t_in;
      step(1);
      checks++;
      if ({cnt_w, tc_w, ovf_w, busy_w, cnt_s, tc_s, ovf_s, busy_s} !== '0) begin
        errors++;
        $display("FAIL reset cyc%0d: got w=%h/%b%b%b s=%h/%b%b%b required all zero",
                 i, cnt_w, tc_w, ovf_w, busy_w, cnt_s, tc_s, ovf_s, busy_s);
      end
    end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_wrap_count();
    logic [W-1:0] exp_seq [4];
    logic [W-1:0] prev;
    exp_seq[0] = 8'd1; exp_seq[1] = 8'd2; exp_seq[2] = 8'd3; exp_seq[3] = 8'd0;
    pulse_clr();
    max_val = 8'd3; enb = 1'b1;
    step(2);
    for (int e = 0; e < 4; e++) begin
      prev = cnt_w;
      t_in = ~t_in;
      step(2);
      checks++;
      if (cnt_w !== prev) begin
        errors++;
        $display("FAIL wrap_latency e%0d: count=%0d required %0d", e, cnt_w, prev);
      end
      step(1);
      checks++;
      if (cnt_w !== exp_seq[e] || tc_w !== (e == 3)) begin
        errors++;
        $display("FAIL wrap_seq e%0d: count=%0d tc=%b required %0d tc=%b",
                 e, cnt_w, tc_w, exp_seq[e], (e == 3));
      end
    end
    step(1);
    checks++;
    if (ovf_w !== 1'b1 || tc_w !== 1'b0) begin
      errors++;
      $display("FAIL wrap_flags: ovf=%b tc=%b required ovf=1 tc=0", ovf_w, tc_w);
    end
  endtask

  task automatic test_saturate();
    int tcs = 0;
    pulse_clr();
    max_val = 8'd5; enb = 1'b1;
    step(2);
    for (int e = 0; e < 8; e++) begin
      t_in = ~t_in;
      for (int c = 0; c < 3; c++) begin
        step(1);
        if (tc_s) tcs++;
      end
    end
    checks++;
    if (cnt_s !== 8'd5 || busy_s !== 1'b0 || ovf_s !== 1'b1 || tcs != 1) begin
      errors++;
      $display("FAIL sat_hold: count=%0d busy=%b ovf=%b tcs=%0d required 5 0 1 1",
               cnt_s, busy_s, ovf_s, tcs);
    end
    pulse_clr();
    checks++;
    if (cnt_s !== '0 || ovf_s !== 1'b0 || busy_s !== 1'b0) begin
      errors++;
      $display("FAIL sat_clr: count=%0d ovf=%b busy=%b required 0 0 0", cnt_s, ovf_s, busy_s);
    end
  endtask

  task automatic test_priority();
    pulse_clr();
    max_val = 8'd20; enb = 1'b1;
    step(2);
    repeat (2) begin t_in = ~t_in; step(3); end
    checks++;
    if (cnt_w !== 8'd2) begin
      errors++;
      $display("FAIL prio_setup: count=%0d required 2", cnt_w);
    end
    t_in = ~t_in;
    step(2);
    load = 1'b1; load_val = 8'd7;
    step(1);
    load = 1'b0;
    step(3);
    checks++;
    if (cnt_w !== 8'd7) begin
      errors++;
      $display("FAIL prio_load: count=%0d required 7", cnt_w);
    end
    t_in = ~t_in;
    step(2);
    load = 1'b1; clr = 1'b1;
    step(1);
    load = 1'b0; clr = 1'b0;
    checks++;
    if (cnt_w !== '0) begin
      errors++;
      $display("FAIL prio_clr: count=%0d required 0", cnt_w);
    end
    step(2);
  endtask

  task automatic test_enable();
    pulse_clr();
    max_val = 8'd20; enb = 1'b1;
    step(2);
    t_in = ~t_in; step(3);
    enb = 1'b0;
    step(2);
    checks++;
    if (busy_w !== 1'b0 || cnt_w !== 8'd1) begin
      errors++;
      $display("FAIL en_idle: busy=%b count=%0d required 0 1", busy_w, cnt_w);
    end
    repeat (3) begin t_in = ~t_in; step(3); end
    enb = 1'b1;
    step(6);
    checks++;
    if (cnt_w !== 8'd1 || busy_w !== 1'b1) begin
      errors++;
      $display("FAIL en_resume: count=%0d busy=%b required 1 1", cnt_w, busy_w);
    end
  endtask

  task automatic test_boundary();
    pulse_clr();
    max_val = 8'd0; enb = 1'b1;
    step(2);
    for (int e = 0; e < 2; e++) begin
      t_in = ~t_in; step(3);
      checks++;
      if (cnt_w !== '0 || tc_w !== 1'b1) begin
        errors++;
        $display("FAIL max0 e%0d: count=%0d tc=%b required 0 1", e, cnt_w, tc_w);
      end
    end
    pulse_clr();
    max_val = 8'd3; load_val = 8'd254; load = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    t_in = ~t_in; step(3);
    checks++;
    if (cnt_w !== 8'd255 || tc_w !== 1'b0) begin
      errors++;
      $display("FAIL above_max: count=%0d tc=%b required 255 0", cnt_w, tc_w);
    end
    t_in = ~t_in; step(3);
    checks++;
    if (cnt_w !== '0 || tc_w !== 1'b0 || ovf_w !== 1'b0) begin
      errors++;
      $display("FAIL rollover: count=%0d tc=%b ovf=%b required 0 0 0", cnt_w, tc_w, ovf_w);
    end
  endtask

`ifdef TOGGLE_COUNTER_DOWN_EN
  task automatic test_down();
    pulse_clr();
    dir = 1'b1; max_val = 8'd4; load_val = 8'd1; load = 1'b1; enb = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    t_in = ~t_in; step(3);
    checks++;
    if (cnt_w !== '0 || tc_w !== 1'b0) begin
      errors++;
      $display("FAIL down_first: count=%0d tc=%b required 0 0", cnt_w, tc_w);
    end
    t_in = ~t_in; step(3);
    checks++;
    if (cnt_w !== 8'd4 || tc_w !== 1'b1 || ovf_w !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap: count=%0d tc=%b ovf=%b required 4 1 1", cnt_w, tc_w, ovf_w);
    end
    dir = 1'b0;
    step(1);
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      step(1);
      checks++;
      if ({cnt_w, tc_w, ovf_w, busy_w} !== {m_cnt[1], m_tc[1], m_ovf[1], m_mode[1] == M_RUN}) begin
        errors++;
        $display("FAIL rand_wrap c%0d: got %h/%b%b%b required %h/%b%b%b", c, cnt_w, tc_w, ovf_w,
                 busy_w, m_cnt[1], m_tc[1], m_ovf[1], m_mode[1] == M_RUN);
      end
      checks++;
      if ({cnt_s, tc_s, ovf_s, busy_s} !== {m_cnt[0], m_tc[0], m_ovf[0], m_mode[0] == M_RUN}) begin
        errors++;
        $display("FAIL rand_sat c%0d: got %h/%b%b%b required %h/%b%b%b", c, cnt_s, tc_s, ovf_s,
                 busy_s, m_cnt[0], m_tc[0], m_ovf[0], m_mode[0] == M_RUN);
      end
      rst_n    = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 2) == 0) t_in = ~t_in;
      enb      = ($urandom_range(0, 9) != 0);
      clr      = ($urandom_range(0, 49) == 0);
      load     = ($urandom_range(0, 29) == 0);
      load_val = W'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) max_val = W'($urandom_range(0, 7));
`ifdef TOGGLE_COUNTER_DOWN_EN
      if ($urandom_range(0, 9) == 0) dir = ~dir;
`endif
    end
    rst_n = 1'b1; clr = 1'b0; load = 1'b0;
    step(1);
  endtask

  initial begin
    test_reset();
    test_wrap_count();
    test_saturate();
    test_priority();
    test_enable();
    test_boundary();
`ifdef TOGGLE_COUNTER_DOWN_EN
    test_down();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
